// File: rtl/noc_rst_seq.sv
// Staggered per-channel reset release sequencer for NoC master/slave interfaces.
// Channels are released one slot at a time; masked channels stay in reset.
module noc_rst_seq #(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned INIT_DLY = 4,
    parameter int unsigned STEP_DLY = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sw_rst_req,
    input  logic [NUM_CH-1:0]               ch_mask,
    output logic [NUM_CH-1:0]               ch_rstn,
    output logic                            busy,
    output logic                            all_rel,
    output logic [$clog2(NUM_CH+1)-1:0]     seq_idx
);

    localparam int unsigned IW   = $clog2(NUM_CH + 1);
    localparam int unsigned MAXD = (INIT_DLY > STEP_DLY) ? INIT_DLY : STEP_DLY;
    localparam int unsigned CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    localparam logic [CW-1:0] CNT_INIT = CW'(INIT_DLY - 1);
    localparam logic [CW-1:0] CNT_STEP = CW'(STEP_DLY - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        REL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic [IW-1:0]       idx_d;
    logic [NUM_CH-1:0]   rstn_d;
    logic                busy_d;
    logic                all_rel_d;

    // State and registered outputs; rst wins over any software request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT;
            cnt     <= CNT_INIT;
            seq_idx <= '0;
            ch_rstn <= '0;
            busy    <= 1'b1;
            all_rel <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            seq_idx <= idx_d;
            ch_rstn <= rstn_d;
            busy    <= busy_d;
            all_rel <= all_rel_d;
        end
    end

    // Next-state and next-output logic; mask is applied on every edge.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        idx_d     = seq_idx;
        rstn_d    = ch_rstn & ch_mask;
        busy_d    = busy;
        all_rel_d = all_rel;

        case (state)
            WAIT: begin
                if (cnt == '0) begin
                    state_d = REL;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            REL: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (seq_idx == IW'(i)) begin
                        rstn_d[i] = ch_mask[i];
                    end
                end
                idx_d = seq_idx + 1'b1;
                if (seq_idx == IDX_LAST) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    all_rel_d = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_STEP;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = WAIT;
                cnt_d   = CNT_INIT;
            end
        endcase

        // Software request restarts exactly like a block reset.
        if (sw_rst_req) begin
            state_d   = WAIT;
            cnt_d     = CNT_INIT;
            idx_d     = '0;
            rstn_d    = '0;
            busy_d    = 1'b1;
            all_rel_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_rst_seq.sv
// Directed self-checking bench for noc_rst_seq (4-channel and 1-channel instances).
module tb_noc_rst_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw  = 1'b0;
    logic [3:0] mask = 4'hF;
    logic [3:0] rstn;
    logic       busy;
    logic       all_rel;
    logic [2:0] idx;

    logic       rst1 = 1'b0;
    logic       sw1  = 1'b0;
    logic [0:0] mask1 = 1'b1;
    logic [0:0] rstn1;
    logic       busy1;
    logic       all_rel1;
    logic [0:0] idx1;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    noc_rst_seq #(.NUM_CH(4), .INIT_DLY(4), .STEP_DLY(2)) u0 (
        .clk(clk), .rst(rst), .sw_rst_req(sw), .ch_mask(mask),
        .ch_rstn(rstn), .busy(busy), .all_rel(all_rel), .seq_idx(idx)
    );

    noc_rst_seq #(.NUM_CH(1), .INIT_DLY(1), .STEP_DLY(2)) u1 (
        .clk(clk), .rst(rst1), .sw_rst_req(sw1), .ch_mask(mask1),
        .ch_rstn(rstn1), .busy(busy1), .all_rel(all_rel1), .seq_idx(idx1)
    );

    task automatic step(input int n);
        for (int s = 0; s < n; s++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        mask = 4'hF; rst = 1'b1; sw = 1'b1;
        step(1);
        total++;
        if ({rstn, busy, all_rel, idx} !== {4'h0, 1'b1, 1'b0, 3'd0})
            $display("FAIL reset_both rstn=%h busy=%b all_rel=%b idx=%0d exp 0/1/0/0", rstn, busy, all_rel, idx);
        else passed++;
        sw = 1'b0;
        step(1);
        total++;
        if ({rstn, busy, all_rel, idx} !== {4'h0, 1'b1, 1'b0, 3'd0})
            $display("FAIL reset_state rstn=%h busy=%b all_rel=%b idx=%0d exp 0/1/0/0", rstn, busy, all_rel, idx);
        else passed++;
        rst = 1'b0;
    endtask

    // Full sequence: rst last high at k, channel i releases at k+5+3i.
    task automatic test_full_mask();
        logic [3:0] er;
        logic [2:0] ei;
        mask = 4'hF; rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            step(1);
            er = '0; ei = '0;
            for (int i = 0; i < 4; i++)
                if (e >= 5 + 3 * i) begin er[i] = 1'b1; ei = ei + 3'd1; end
            total++;
            if ({rstn, busy, all_rel, idx} !== {er, (e < 14), (e >= 14), ei})
                $display("FAIL full_k+%0d rstn=%h busy=%b all_rel=%b idx=%0d exp %h/%b/%b/%0d",
                         e, rstn, busy, all_rel, idx, er, (e < 14), (e >= 14), ei);
            else passed++;
        end
    endtask

    // Masked channel 2 consumes its slot but stays in reset.
    task automatic test_masked();
        logic [3:0] er;
        logic [2:0] ei;
        mask = 4'b1011; rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            step(1);
            er = '0; ei = '0;
            if (e >= 5)  begin er[0] = 1'b1; ei = ei + 3'd1; end
            if (e >= 8)  begin er[1] = 1'b1; ei = ei + 3'd1; end
            if (e >= 11) ei = ei + 3'd1;
            if (e >= 14) begin er[3] = 1'b1; ei = ei + 3'd1; end
            total++;
            if ({rstn, busy, all_rel, idx} !== {er, (e < 14), (e >= 14), ei})
                $display("FAIL masked_k+%0d rstn=%h busy=%b all_rel=%b idx=%0d exp %h/%b/%b/%0d",
                         e, rstn, busy, all_rel, idx, er, (e < 14), (e >= 14), ei);
            else passed++;
        end
    endtask

    task automatic test_sw_restart();
        mask = 4'hF; rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(8);
        total++;
        if (rstn !== 4'h3) $display("FAIL sw_pre rstn=%h exp 3", rstn); else passed++;
        sw = 1'b1;
        step(1);
        sw = 1'b0;
        total++;
        if ({rstn, busy, all_rel, idx} !== {4'h0, 1'b1, 1'b0, 3'd0})
            $display("FAIL sw_abort rstn=%h busy=%b all_rel=%b idx=%0d exp 0/1/0/0", rstn, busy, all_rel, idx);
        else passed++;
        step(4);
        total++;
        if (rstn !== 4'h0) $display("FAIL sw_k+13 rstn=%h exp 0", rstn); else passed++;
        step(1);
        total++;
        if (rstn !== 4'h1) $display("FAIL sw_k+14 rstn=%h exp 1", rstn); else passed++;
        step(8);
        total++;
        if ({rstn, busy, all_rel} !== {4'h7, 1'b1, 1'b0})
            $display("FAIL sw_k+22 rstn=%h busy=%b all_rel=%b exp 7/1/0", rstn, busy, all_rel);
        else passed++;
        step(1);
        total++;
        if ({rstn, busy, all_rel, idx} !== {4'hF, 1'b0, 1'b1, 3'd4})
            $display("FAIL sw_k+23 rstn=%h busy=%b all_rel=%b idx=%0d exp F/0/1/4", rstn, busy, all_rel, idx);
        else passed++;
    endtask

    // Runs in DONE left by the previous test.
    task automatic test_done_mask();
        mask = 4'b1101;
        step(1);
        total++;
        if ({rstn, all_rel, busy} !== {4'b1101, 1'b1, 1'b0})
            $display("FAIL done_clear rstn=%h all_rel=%b busy=%b exp D/1/0", rstn, all_rel, busy);
        else passed++;
        mask = 4'hF;
        step(5);
        total++;
        if ({rstn, all_rel, idx} !== {4'b1101, 1'b1, 3'd4})
            $display("FAIL done_reset rstn=%h all_rel=%b idx=%0d exp D/1/4", rstn, all_rel, idx);
        else passed++;
        sw = 1'b1;
        step(1);
        sw = 1'b0;
        step(14);
        total++;
        if ({rstn, all_rel} !== {4'hF, 1'b1})
            $display("FAIL done_resequence rstn=%h all_rel=%b exp F/1", rstn, all_rel);
        else passed++;
    endtask

    task automatic test_mid_rst();
        mask = 4'hF; rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(9);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        total++;
        if ({rstn, busy, idx} !== {4'h0, 1'b1, 3'd0})
            $display("FAIL mid_rst rstn=%h busy=%b idx=%0d exp 0/1/0", rstn, busy, idx);
        else passed++;
        step(4);
        total++;
        if (rstn !== 4'h0) $display("FAIL mid_rst_k+4 rstn=%h exp 0", rstn); else passed++;
        step(1);
        total++;
        if (rstn !== 4'h1) $display("FAIL mid_rst_k+5 rstn=%h exp 1", rstn); else passed++;
        step(9);
        total++;
        if ({rstn, all_rel} !== {4'hF, 1'b1})
            $display("FAIL mid_rst_k+14 rstn=%h all_rel=%b exp F/1", rstn, all_rel);
        else passed++;
    endtask

    task automatic test_held_sw();
        mask = 4'hF; sw = 1'b1;
        step(3);
        sw = 1'b0;
        step(4);
        total++;
        if ({rstn, busy} !== {4'h0, 1'b1})
            $display("FAIL held_sw_m+4 rstn=%h busy=%b exp 0/1", rstn, busy);
        else passed++;
        step(1);
        total++;
        if (rstn !== 4'h1) $display("FAIL held_sw_m+5 rstn=%h exp 1", rstn); else passed++;
    endtask

    task automatic test_single();
        rst1 = 1'b1;
        step(1);
        rst1 = 1'b0;
        total++;
        if ({rstn1, busy1, all_rel1, idx1} !== {1'b0, 1'b1, 1'b0, 1'b0})
            $display("FAIL single_reset rstn=%b busy=%b all_rel=%b idx=%0d exp 0/1/0/0", rstn1, busy1, all_rel1, idx1);
        else passed++;
        step(1);
        total++;
        if ({rstn1, busy1, all_rel1} !== {1'b0, 1'b1, 1'b0})
            $display("FAIL single_k+1 rstn=%b busy=%b all_rel=%b exp 0/1/0", rstn1, busy1, all_rel1);
        else passed++;
        step(1);
        total++;
        if ({rstn1, busy1, all_rel1, idx1} !== {1'b1, 1'b0, 1'b1, 1'b1})
            $display("FAIL single_k+2 rstn=%b busy=%b all_rel=%b idx=%0d exp 1/0/1/1", rstn1, busy1, all_rel1, idx1);
        else passed++;
    endtask

    initial begin
        step(1);
        test_reset();
        test_full_mask();
        test_masked();
        test_sw_restart();
        test_done_mask();
        test_mid_rst();
        test_held_sw();
        test_single();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
